// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one shared inverse-round datapath reused for NR cycles.
// Round keys are expanded one word per cycle into a register file when a key is loaded.
module aes_decrypt_iter #(
    parameter int unsigned KEY_BITS = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        cipher,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        plain,
    output logic                key_loaded,
    output logic [3:0]          round_idx
);

    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned WW = $clog2(NW);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_decrypt_iter: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [2:0] {StNokey, StKexp, StReady, StDec, StDone} st_e;

    // ---------------------------------------------------------------- GF(2^8) primitives

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    // ---------------------------------------------------------------- round primitives
    // Byte n of a block sits at bits [127-8n -: 8]; column c holds bytes 4c..4c+3.

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                               gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                               gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                               gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                               gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w_in);
        return {sbox(w_in[31:24]), sbox(w_in[23:16]), sbox(w_in[15:8]), sbox(w_in[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w_in);
        return {w_in[23:0], w_in[31:24]};
    endfunction

    // ---------------------------------------------------------------- state

    st_e            st;
    logic [31:0]    w [NW];
    logic [WW-1:0]  wcnt;       // index of the word being expanded
    logic [2:0]     kpos;       // wcnt mod NK
    logic [7:0]     rcon;       // Rcon for the next wcnt with kpos == 0
    logic [127:0]   state_reg;

    logic           key_take;
    logic [31:0]    w_prev;
    logic [31:0]    temp;
    logic [31:0]    w_new;
    logic [3:0]     rk_idx;
    logic [WW-1:0]  rk_base;
    logic [127:0]   rk;
    logic [127:0]   isb;
    logic [127:0]   rk_added;
    logic [127:0]   round_out;

    // Readies come from state (and key_valid, which outranks a block offer in READY)
    always_comb begin
        key_ready = (st == StNokey) || (st == StReady);
        in_ready  = (st == StReady) && !key_valid;
        key_take  = key_valid && key_ready;
    end

    // Next key-schedule word from w[wcnt-1] and w[wcnt-NK]
    always_comb begin
        w_prev = w[wcnt - WW'(1)];
        if (kpos == 3'd0) begin
            temp = sub_word(rot_word(w_prev)) ^ {rcon, 24'h000000};
        end else if (NK == 8 && kpos == 3'd4) begin
            temp = sub_word(w_prev);
        end else begin
            temp = w_prev;
        end
        w_new = w[wcnt - WW'(NK)] ^ temp;
    end

    // Round-key select and the shared inverse-round datapath
    always_comb begin
        rk_idx    = (st == StReady) ? 4'(NR) : round_idx;
        rk_base   = WW'({rk_idx, 2'b00});
        rk        = {w[rk_base], w[rk_base + WW'(1)], w[rk_base + WW'(2)], w[rk_base + WW'(3)]};
        isb       = inv_sub_bytes(inv_shift_rows(state_reg));
        rk_added  = add_round_key(isb, rk);
        round_out = inv_mix_columns(rk_added);
    end

    // Round-key file; contents are don't-care until an expansion completes
    always_ff @(posedge clk) begin
        if (key_take) begin
            for (int j = 0; j < int'(NK); j++) w[j] <= key[KEY_BITS-1-32*j -: 32];
        end else if (st == StKexp) begin
            w[wcnt] <= w_new;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= StNokey;
            wcnt       <= '0;
            kpos       <= 3'd0;
            rcon       <= 8'h01;
            state_reg  <= '0;
            round_idx  <= 4'd0;
            key_loaded <= 1'b0;
            out_valid  <= 1'b0;
            plain      <= '0;
        end else begin
            unique case (st)
                StNokey, StReady: begin
                    if (key_take) begin
                        wcnt       <= WW'(NK);
                        kpos       <= 3'd0;
                        rcon       <= 8'h01;
                        key_loaded <= 1'b0;
                        st         <= StKexp;
                    end else if (st == StReady && in_valid) begin
                        state_reg <= add_round_key(cipher, rk);
                        round_idx <= 4'(NR - 1);
                        st        <= StDec;
                    end
                end
                StKexp: begin
                    if (kpos == 3'd0) rcon <= xtime(rcon);
                    kpos <= (kpos == 3'(NK - 1)) ? 3'd0 : kpos + 3'd1;
                    if (wcnt == WW'(NW - 1)) begin
                        key_loaded <= 1'b1;
                        st         <= StReady;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                StDec: begin
                    if (round_idx != 4'd0) begin
                        state_reg <= round_out;
                        round_idx <= round_idx - 4'd1;
                    end else begin
                        plain     <= rk_added;
                        out_valid <= 1'b1;
                        st        <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        st        <= StReady;
                    end
                end
                default: st <= StNokey;
            endcase
        end
    end

endmodule
